// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BF16 widths, constants, FSM state and class flags
package bf16_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 7;
    localparam int EXP_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;
    typedef enum logic [2:0] {IDLE, CLASSIFY, DIV, NORM, DONE} state_t;
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } bf16_class_t;
endpackage

// File: rtl/bf16_divider_if.sv
// bf16_divider_if: operand/result handshake bus (in_valid/in_ready, A, B, out_valid/out_ready, O, dz)
interface bf16_divider_if;
    logic in_valid, in_ready, out_valid, out_ready, dz;
    logic [15:0] A, B, O;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, O, dz);
    modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, O, dz);
endinterface

// File: rtl/bf16_special_classify.sv
// bf16_special_classify: decode NaN/inf/zero of a BF16 magnitude x[14:0] (subnormals count as zero) into c
module bf16_special_classify
    import bf16_pkg::*;
(
    input  logic [14:0]  x,
    output bf16_class_t  c
);
    assign c.nan = (&x[14:7]) & (|x[6:0]);
    assign c.inf = (&x[14:7]) & ~(|x[6:0]);
    assign c.zero = ~(|x[14:7]);
endmodule

// File: rtl/bf16_divider.sv
// bf16_divider: iterative BF16 divider O=A/B with dz flag; ports clk, rst, bus (slave side of bf16_divider_if)
module bf16_divider
    import bf16_pkg::*;
#(
    parameter bit ROUND_EN = 1'b0
) (
    input logic           clk,
    input logic           rst,
    bf16_divider_if.slave bus
);
    state_t state;
    logic [15:0] ra, rb, spec_o, norm_o;
    logic signed [9:0] e, en, ef;
    logic [7:0] mb, mant;
    logic [8:0] rem, rem_sub, qn;
    logic [9:0] q;
    logic [3:0] cnt;
    logic s, nan_case, special, dz_n, ge, up, st;
    bf16_class_t ca, cb;

    bf16_special_classify u_ca (.x(ra[14:0]), .c(ca));
    bf16_special_classify u_cb (.x(rb[14:0]), .c(cb));

    assign bus.in_ready = state == IDLE;

    always_comb begin
        s = ra[15] ^ rb[15];
        nan_case = ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
        special = nan_case | ca.inf | cb.zero | ca.zero | cb.inf;
        dz_n = ~nan_case & ~ca.inf & cb.zero;
        spec_o = nan_case ? BF16_QNAN : (ca.inf | cb.zero) ? (s ? BF16_NINF : BF16_PINF) : {s, 15'h0};
        ge = rem >= {1'b0, mb};
        rem_sub = ge ? rem - {1'b0, mb} : rem;
        qn = q[9] ? q[8:0] : {q[7:0], 1'b0};
        en = q[9] ? e : e - 10'sd1;
        st = qn[0] | (|rem);
        up = ROUND_EN && qn[1] && (st || qn[2]);
        mant = {1'b0, qn[8:2]} + {7'd0, up};
        ef = en + {9'd0, mant[7]};
        norm_o = ef >= 10'sd255 ? {s, 8'hFF, 7'h0} : ef <= 10'sd0 ? {s, 15'h0} : {s, ef[7:0], mant[6:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.out_valid <= 1'b0;
            bus.O <= 16'h0;
            bus.dz <= 1'b0;
            cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ra <= bus.A;
                    rb <= bus.B;
                    state <= CLASSIFY;
                end
                CLASSIFY: if (special) begin
                    bus.O <= spec_o;
                    bus.dz <= dz_n;
                    bus.out_valid <= 1'b1;
                    state <= DONE;
                end else begin
                    e <= {2'b0, ra[14:7]} - {2'b0, rb[14:7]} + 10'(EXP_BIAS);
                    mb <= {1'b1, rb[6:0]};
                    rem <= {2'b01, ra[6:0]};
                    q <= 10'd0;
                    cnt <= 4'd0;
                    state <= DIV;
                end
                DIV: begin
                    rem <= rem_sub << 1;
                    q <= {q[8:0], ge};
                    cnt <= cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
                    state <= cnt == 4'd9 ? NORM : DIV;
                end
                NORM: begin
                    bus.O <= norm_o;
                    bus.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.dz <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_divider.sv
// tb_bf16_divider: scoreboard bench for truncating and RNE bf16_divider instances against an arithmetic model
module tb_bf16_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [15:0] A = 16'h0, B = 16'h0;
    int vectors = 0;
    int miscompares = 0;
    logic [16:0] q0[$], q1[$];

    bf16_divider_if b0 ();
    bf16_divider_if b1 ();

    assign b0.in_valid = in_valid;
    assign b0.A = A;
    assign b0.B = B;
    assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;
    assign b1.A = A;
    assign b1.B = B;
    assign b1.out_ready = out_ready;

    bf16_divider #(.ROUND_EN(1'b0)) u_trunc (.clk(clk), .rst(rst), .bus(b0.slave));
    bf16_divider #(.ROUND_EN(1'b1)) u_rne (.clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input bit rnd);
        int ea = int'(a[14:7]);
        int eb = int'(b[14:7]);
        int fa = int'(a[6:0]);
        int fb = int'(b[6:0]);
        bit s = a[15] ^ b[15];
        bit za = ea == 0;
        bit zb = eb == 0;
        bit ia = ea == 255 && fa == 0;
        bit ib = eb == 255 && fb == 0;
        bit na = ea == 255 && fa != 0;
        bit nb = eb == 255 && fb != 0;
        logic [15:0] inf = s ? 16'hFF80 : 16'h7F80;
        logic [15:0] zero = {s, 15'h0};
        int e, q, fr, g, st;
        if (na || nb || (za && zb) || (ia && ib)) return {1'b0, 16'h7FC0};
        if (ia) return {1'b0, inf};
        if (zb) return {1'b1, inf};
        if (za || ib) return {1'b0, zero};
        e = ea - eb + 127;
        q = ((128 + fa) * 512) / (128 + fb);
        st = (((128 + fa) * 512) % (128 + fb)) != 0 ? 1 : 0;
        if (q < 512) begin
            q = q * 2;
            e = e - 1;
        end
        fr = (q >> 2) & 127;
        g = (q >> 1) & 1;
        st = st | (q & 1);
        if (rnd && g != 0 && (st != 0 || (fr & 1) != 0)) fr++;
        if (fr == 128) begin
            fr = 0;
            e++;
        end
        if (e >= 255) return {1'b0, inf};
        if (e <= 0) return {1'b0, zero};
        return {1'b0, s, e[7:0], fr[6:0]};
    endfunction

    function automatic logic [15:0] rnd_op();
        int k = $urandom_range(0, 9);
        logic [7:0] ex;
        logic [6:0] fr;
        ex = k == 0 ? 8'd0 : k == 1 ? 8'hFF : k < 6 ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
        fr = $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom);
        return {1'($urandom), ex, fr};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (b0.out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out_trunc: got %h expected none", b0.O);
                end else chk("result_trunc", 32'({b0.dz, b0.O}), 32'(q0.pop_front()));
            end
            if (b1.out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out_rne: got %h expected none", b1.O);
                end else chk("result_rne", 32'({b1.dz, b1.O}), 32'(q1.pop_front()));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e0, input logic [16:0] e1);
        int n = 0;
        q0.push_back(e0);
        q1.push_back(e1);
        A = a;
        B = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b0.in_ready && n < 200);
        if (!b0.in_ready) timeout("accept");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input int lat, input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!b0.out_valid && n < 40);
        chk(nm, 32'(n), 32'(lat));
    endtask

    task automatic drain(input bit bp);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            @(posedge clk);
            #1 n++;
            if (bp) out_ready = $urandom_range(0, 2) != 0;
        end
        out_ready = 1'b1;
        if (n >= 400) timeout("drain");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_O", 32'(b0.O), 32'h0);
        chk("rst_dz", 32'(b1.dz), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(16'h3F80, 16'h4000, 17'h03F00, 17'h03F00);
        wait_out(12, "latency_normal");
        drain(0);
        send(16'hC000, 16'h4000, 17'h0BF80, 17'h0BF80);
        drain(0);
        send(16'h3F80, 16'h4040, 17'h03EAA, 17'h03EAB);
        drain(0);
        send(16'h4000, 16'h0000, 17'h17F80, 17'h17F80);
        wait_out(1, "latency_special");
        drain(0);
        send(16'h0000, 16'h0000, 17'h07FC0, 17'h07FC0);
        drain(0);
        send(16'h7F00, 16'h3E80, 17'h07F80, 17'h07F80);
        drain(0);
        send(16'h0080, 16'h4B00, 17'h00000, 17'h00000);
        drain(0);

        out_ready = 1'b0;
        send(16'h4040, 16'h3F80, 17'h04040, 17'h04040);
        wait_out(12, "latency_bp");
        A = 16'h4000;
        B = 16'h4000;
        in_valid = 1'b1;
        q0.push_back(17'h03F80);
        q1.push_back(17'h03F80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_O", 32'(b0.O), 32'h4040);
            chk("bp_in_ready", 32'(b0.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready", 32'(b0.in_ready), 32'd1);
        @(posedge clk);
        #1 chk("b2b_accept", 32'(b0.in_ready), 32'd0);
        in_valid = 1'b0;
        drain(0);

        send(16'h3F80, 16'h4040, 17'h03EAA, 17'h03EAB);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 chk("midrst_in_ready", 32'(b0.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(b0.out_valid), 32'd0);
        chk("midrst_O", 32'(b0.O), 32'h0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 send(16'h4000, 16'h4000, 17'h03F80, 17'h03F80);
        drain(0);

        for (int i = 0; i < 150; i++) begin
            logic [15:0] a, b;
            a = rnd_op();
            b = rnd_op();
            send(a, b, model(a, b, 1'b0), model(a, b, 1'b1));
            drain(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
